// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int REG_DBUS  = 32;
  localparam int IMEM_DBUS = 32;
  localparam int IMEM_ABUS = 14;

  localparam logic [IMEM_DBUS-1:0] INST_NOP     = 32'h0000_0013;
  localparam logic [REG_DBUS-1:0]  RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [REG_DBUS-1:0]  pc;
    logic [IMEM_DBUS-1:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: IMEM request/response, redirect input and the decode valid/ready handshake.
interface if_fetch_if #(
  parameter int IMEM_AW = 14
);
  logic               imem_en_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_data_i;
  logic               redirect_i;
  logic [31:0]        redirect_pc_i;
  logic               id_ready_i;
  logic               valid_o;
  logic [31:0]        inst_o;
  logic [31:0]        pc_o;

  modport master (
    output imem_en_o, imem_addr_o, valid_o, inst_o, pc_o,
    input  imem_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  imem_en_o, imem_addr_o, valid_o, inst_o, pc_o,
    output imem_data_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_fetch_buf.sv
// Two-entry shift FIFO of {pc, inst}; entry 0 is always the head presented to decode.
module if_fetch_fetch_buf
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  fetch_ent_t push_ent_i,
  output logic [1:0] count_o,
  output logic       valid_o,
  output fetch_ent_t head_o
);

  fetch_ent_t ent0_q, ent0_d;
  fetch_ent_t ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = push_ent_i;
          else               ent1_d = push_ent_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves entry 0 untouched so pc_o keeps its value.
          if (cnt_q == 2'd2) ent0_d = ent1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = push_ent_i;
          end else begin
            ent0_d = push_ent_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '{pc: '0, inst: INST_NOP};
      ent1_q <= '{pc: '0, inst: INST_NOP};
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign valid_o     = (cnt_q != 2'd0);
  assign head_o.pc   = ent0_q.pc;
  assign head_o.inst = valid_o ? ent0_q.inst : INST_NOP;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single in-flight IMEM request tracking, issue throttling and
// redirect handling in front of a 2-entry decode buffer.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          IMEM_AW   = IMEM_ABUS,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_infl_q, pc_infl_d;
  logic        inflight_q, inflight_d;

  logic        pop, push, issue, en_req;
  logic [2:0]  occ;
  logic [1:0]  buf_cnt;
  logic        buf_valid;
  fetch_ent_t  head, push_ent;

  always_comb begin
    pop      = buf_valid & bus.id_ready_i & ~bus.redirect_i;
    push     = inflight_q & ~bus.redirect_i;
    // Occupancy one cycle from now, before deciding whether a new request still fits.
    occ      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (occ < 3'd2);
    push_ent = '{pc: pc_infl_q, inst: bus.imem_data_i};

    pc_d       = pc_q;
    pc_infl_d  = pc_infl_q;
    inflight_d = 1'b0;
    en_req     = 1'b0;
    if (bus.redirect_i) begin
      en_req     = 1'b1;
      pc_infl_d  = bus.redirect_pc_i;
      pc_d       = bus.redirect_pc_i + 32'd1;
      inflight_d = 1'b1;
    end else if (issue) begin
      en_req     = 1'b1;
      pc_infl_d  = pc_q;
      pc_d       = pc_q + 32'd1;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_infl_q  <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_infl_q  <= pc_infl_d;
      inflight_q <= inflight_d;
    end
  end

  if_fetch_fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (bus.redirect_i),
    .push_ent_i (push_ent),
    .count_o    (buf_cnt),
    .valid_o    (buf_valid),
    .head_o     (head)
  );

  assign bus.imem_en_o   = rst_n & en_req;
  assign bus.imem_addr_o = bus.redirect_i ? bus.redirect_pc_i[IMEM_AW-1:0] : pc_q[IMEM_AW-1:0];
  assign bus.valid_o     = buf_valid;
  assign bus.inst_o      = head.inst;
  assign bus.pc_o        = head.pc;

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (({1'b0, buf_cnt} + {2'b00, inflight_q}) <= 3'(BUF_DEPTH)));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed per-cycle vector table, then randomized redirect/stall traffic
// against a delivered-sequence reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if #(.IMEM_AW(AW)) bus ();

  if_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    return {a, 18'h0} ^ ({18'h0, a} * 32'h0001_9E37) ^ 32'h5A5A_0003;
  endfunction

  always @(posedge clk) if (bus.imem_en_o) bus.imem_data_i <= mem_f(bus.imem_addr_o);

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_en;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic rr, input logic [31:0] rp, input logic v,
                     input logic [31:0] p, input logic e, input logic [31:0] a);
    vec_t x;
    x = '{ready: rd, redir: rr, rpc: rp, exp_valid: v, exp_pc: p, exp_en: e, exp_addr: a};
    tbl.push_back(x);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          wait_n;
    logic        r_ready, r_redir;
    logic [31:0] r_rpc;

    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i    = 1'b0;

    // cycle-by-cycle from reset release: ready, redirect, target | valid, pc | en, addr
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0, 1, 2);
    add(1, 0, 0, 1, 1, 1, 3);
    add(1, 0, 0, 1, 2, 1, 4);
    add(1, 0, 0, 1, 3, 1, 5);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 4, 0, 0);
    add(1, 0, 0, 1, 4, 1, 6);
    add(1, 0, 0, 1, 5, 1, 7);
    add(1, 0, 0, 1, 6, 1, 8);
    add(0, 0, 0, 1, 7, 0, 0);
    add(0, 0, 0, 1, 7, 0, 0);
    add(1, 1, 32'h40, 1, 7, 1, 32'h40);
    add(1, 0, 0, 0, 0, 1, 32'h41);
    add(1, 0, 0, 1, 32'h40, 1, 32'h42);
    add(1, 0, 0, 1, 32'h41, 1, 32'h43);
    add(1, 1, 32'h10, 1, 32'h42, 1, 32'h10);
    add(1, 1, 32'h20, 0, 0, 1, 32'h20);
    add(1, 0, 0, 0, 0, 1, 32'h21);
    add(1, 0, 0, 1, 32'h20, 1, 32'h22);
    add(1, 0, 0, 1, 32'h21, 1, 32'h23);
    add(1, 1, 32'hFFFF_FFFF, 1, 32'h22, 1, 32'h3FFF);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFF, 1, 1);
    add(1, 0, 0, 1, 0, 1, 2);
    add(1, 0, 0, 1, 1, 1, 3);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_inst", bus.inst_o, INST_NOP);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_en", 32'(bus.imem_en_o), 32'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      bus.id_ready_i    = tbl[i].ready;
      bus.redirect_i    = tbl[i].redir;
      bus.redirect_pc_i = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), bus.pc_o, tbl[i].exp_pc);
        chk($sformatf("v%0d_inst", i), bus.inst_o, mem_f(tbl[i].exp_pc[AW-1:0]));
      end else begin
        chk($sformatf("v%0d_inst", i), bus.inst_o, INST_NOP);
      end
      chk($sformatf("v%0d_en", i), 32'(bus.imem_en_o), 32'(tbl[i].exp_en));
      if (tbl[i].exp_en)
        chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr_o), tbl[i].exp_addr & 32'h3FFF);
    end

    // Reset pulse while a request is in flight.
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.id_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_inst", bus.inst_o, INST_NOP);
    chk("midrst_en", 32'(bus.imem_en_o), 32'd0);
    @(negedge clk);

    // Randomized traffic after reset release, checked against the delivered-sequence model.
    exp_pc = 32'h0;
    wait_n = 2;
    for (int n = 0; n < 600; n++) begin
      if (n != 0) @(negedge clk);
      else        rst_n = 1'b1;
      r_ready = ($urandom_range(0, 9) < 7);
      r_redir = (n >= 3) && ($urandom_range(0, 11) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                            : $urandom;
      bus.id_ready_i    = r_ready;
      bus.redirect_i    = r_redir;
      bus.redirect_pc_i = r_rpc;
      #1;
      if (wait_n > 0) begin
        chk("rnd_valid_lo", 32'(bus.valid_o), 32'd0);
        chk("rnd_inst_nop", bus.inst_o, INST_NOP);
      end else begin
        chk("rnd_valid_hi", 32'(bus.valid_o), 32'd1);
        chk("rnd_pc", bus.pc_o, exp_pc);
        chk("rnd_inst", bus.inst_o, mem_f(exp_pc[AW-1:0]));
      end
      if (n == 0) begin
        chk("restart_en", 32'(bus.imem_en_o), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr_o), 32'h0);
      end
      if (r_redir) begin
        chk("redir_en", 32'(bus.imem_en_o), 32'd1);
        chk("redir_addr", 32'(bus.imem_addr_o), r_rpc & 32'h3FFF);
      end
      if (r_redir) begin
        exp_pc = r_rpc;
        wait_n = 1;
      end else if (wait_n > 0) begin
        wait_n--;
      end else if (r_ready) begin
        exp_pc = exp_pc + 32'd1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
